// File: rtl/mem_responder.sv
// Memory-side responder: unified word RAM, small MMIO window, and a boot sequencer (clear, load, run).
// Reads are combinational from mem_addr; all state updates on the rising clk edge.
module mem_responder #(
  parameter int MEM_WORDS = 256,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          mem_addr,
  input  logic [31:0]          mem_wdata,
  input  logic                 mem_wen,
  output logic [31:0]          mem_rdata,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [31:0]          load_data,
  input  logic                 load_last,
  output logic                 cpu_hold,
  output logic [7:0]           leds,
  output logic                 err_sticky
);

  typedef enum logic [1:0] {CLEAR, LOAD, RUN} state_t;

  state_t               state, state_nxt;
  logic [ADDR_BITS-1:0] clr_cnt;
  logic [31:0]          ram [MEM_WORDS];
  logic [31:0]          cycle_cnt;
  logic [31:0]          scratch;

  logic                 in_run, is_ram, is_mmio, unmapped, beat, mmio_wr;
  logic [3:0]           off;
  logic                 ram_we;
  logic [ADDR_BITS-1:0] ram_waddr;
  logic [31:0]          ram_wdata;

  assign in_run   = (state == RUN);
  assign is_ram   = (mem_addr < 32'(MEM_WORDS));
  assign is_mmio  = (mem_addr[31:4] == 28'hFFFFFFF);
  assign unmapped = !is_ram && !is_mmio;
  assign off      = mem_addr[3:0];
  assign beat     = (state == LOAD) && load_valid && load_ready;
  assign mmio_wr  = in_run && mem_wen && is_mmio;

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (clr_cnt == {ADDR_BITS{1'b1}}) state_nxt = LOAD;
      LOAD:    if (beat && load_last) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = CLEAR;
    endcase
  end

  // load_ready and cpu_hold are registered copies of the next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= CLEAR;
      clr_cnt    <= '0;
      cpu_hold   <= 1'b1;
      load_ready <= 1'b0;
    end else begin
      state      <= state_nxt;
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
      load_ready <= (state_nxt == LOAD);
      cpu_hold   <= (state_nxt != RUN);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      leds       <= '0;
      cycle_cnt  <= '0;
      scratch    <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (mmio_wr && off == 4'h0) leds <= mem_wdata[7:0];
      if (mmio_wr && off == 4'h3) scratch <= mem_wdata;
      if (in_run) cycle_cnt <= (mmio_wr && off == 4'h1) ? 32'h0 : cycle_cnt + 32'h1;
      if (in_run && unmapped && (mem_wen || !cpu_hold)) err_sticky <= 1'b1;
    end
  end

  // Single RAM write port shared by the clear sweep, the loader and the core.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    if (state == CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_cnt;
    end else if (beat) begin
      ram_we    = 1'b1;
      ram_waddr = load_addr;
      ram_wdata = load_data;
    end else if (in_run && mem_wen && is_ram) begin
      ram_we    = 1'b1;
      ram_waddr = mem_addr[ADDR_BITS-1:0];
      ram_wdata = mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && ram_we) ram[ram_waddr] <= ram_wdata;
  end

  always_comb begin
    mem_rdata = 32'h0;
    if (in_run) begin
      if (is_ram) begin
        mem_rdata = ram[mem_addr[ADDR_BITS-1:0]];
      end else if (is_mmio) begin
        case (off)
          4'h0:    mem_rdata = {24'h0, leds};
          4'h1:    mem_rdata = cycle_cnt;
          4'h2:    mem_rdata = {30'h0, err_sticky, 1'b1};
          4'h3:    mem_rdata = scratch;
          default: mem_rdata = 32'h0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a behavioural model of the boot flow and address map.
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0, mem_rdata;
  logic        mem_wen = 1'b0;
  logic        load_valid = 1'b0, load_ready, load_last = 1'b0;
  logic [7:0]  load_addr = '0;
  logic [31:0] load_data = '0;
  logic        cpu_hold, err_sticky;
  logic [7:0]  leds;

  mem_responder #(.MEM_WORDS(256), .ADDR_BITS(8)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
    .mem_rdata(mem_rdata), .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr),
    .load_data(load_data), .load_last(load_last), .cpu_hold(cpu_hold), .leds(leds),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_ram [256];
  logic [7:0]  m_leds;
  logic [31:0] m_cnt, m_scratch;
  logic        m_err, m_run;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (!m_run) return 32'h0;
    if (a < 32'd256) return m_ram[a[7:0]];
    if (a[31:4] != 28'hFFFFFFF) return 32'h0;
    case (a[3:0])
      4'h0:    return {24'h0, m_leds};
      4'h1:    return m_cnt;
      4'h2:    return {30'h0, m_err, 1'b1};
      4'h3:    return m_scratch;
      default: return 32'h0;
    endcase
  endfunction

  // One core cycle: drive, check the combinational read, clock, update model, check registers.
  task automatic core_cycle(input logic [31:0] a, input logic [31:0] d, input logic w,
                            output logic [31:0] rd);
    logic mmio;
    mem_addr = a; mem_wdata = d; mem_wen = w;
    #1;
    rd = mem_rdata;
    check("rdata", rd, m_read(a));
    @(posedge clk);
    if (m_run) begin
      mmio = (a[31:4] == 28'hFFFFFFF);
      if (w && a < 32'd256) m_ram[a[7:0]] = d;
      if (a >= 32'd256 && !mmio) m_err = 1'b1;
      if (w && mmio && a[3:0] == 4'h0) m_leds = d[7:0];
      if (w && mmio && a[3:0] == 4'h3) m_scratch = d;
      m_cnt = (w && a == 32'hFFFFFFF1) ? 32'h0 : m_cnt + 32'h1;
    end
    #1;
    mem_wen = 1'b0;
    check("leds", 32'(leds), 32'(m_leds));
    check("err_sticky", 32'(err_sticky), 32'(m_err));
    check("cpu_hold", 32'(cpu_hold), 32'(!m_run));
  endtask

  task automatic do_reset();
    int bad;
    reset = 1'b0; load_valid = 1'b0; load_last = 1'b0; mem_wen = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    m_run = 1'b0; m_leds = '0; m_cnt = '0; m_scratch = '0; m_err = 1'b0;
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst_load_ready", 32'(load_ready), 32'd0);
    check("rst_leds", 32'(leds), 32'd0);
    check("rst_err", 32'(err_sticky), 32'd0);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (load_ready !== 1'b0 || cpu_hold !== 1'b1) bad++;
      @(posedge clk);
      #1;
    end
    check("clear_cycles_bad", 32'(bad), 32'd0);
    check("load_ready_257", 32'(load_ready), 32'd1);
    for (int i = 0; i < 256; i++) m_ram[i] = 32'h0;
  endtask

  task automatic load_beat(input logic [7:0] a, input logic [31:0] d, input logic last);
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
    load_valid = 1'b1; load_addr = a; load_data = d; load_last = last;
    check("load_ready", 32'(load_ready), 32'd1);
    @(posedge clk);
    m_ram[a] = d;
    if (last) m_run = 1'b1;
    #1;
    load_valid = 1'b0; load_last = 1'b0;
    check("hold_after_beat", 32'(cpu_hold), 32'(!last));
  endtask

  task automatic readback_all();
    logic [31:0] rd;
    for (int i = 0; i < 256; i++) core_cycle(32'(i), 32'h0, 1'b0, rd);
  endtask

  initial begin
    logic [31:0] rd, a0, b0, addr;
    int n;

    do_reset();
    load_beat(8'd0, 32'h20010005, 1'b0);
    load_beat(8'd1, 32'h8C020000, 1'b0);
    load_beat(8'd2, 32'hDEADBEEF, 1'b1);
    core_cycle(32'd1, 32'h0, 1'b0, rd);
    check("img_word1", rd, 32'h8C020000);
    readback_all();

    core_cycle(32'hFFFFFFF0, 32'h000001A5, 1'b1, rd);
    check("leds_a5", 32'(leds), 32'hA5);
    core_cycle(32'hFFFFFFF0, 32'h0, 1'b0, rd);
    check("leds_read", rd, 32'h000000A5);

    core_cycle(32'hFFFFFFF1, 32'h0, 1'b0, a0);
    n = $urandom_range(3, 20);
    repeat (n - 1) core_cycle(32'd0, 32'h0, 1'b0, rd);
    core_cycle(32'hFFFFFFF1, 32'h0, 1'b0, b0);
    check("cnt_diff", b0 - a0, 32'(n));

    core_cycle(32'hFFFFFFF1, $urandom, 1'b1, rd);
    core_cycle(32'hFFFFFFF1, 32'h0, 1'b0, rd);
    core_cycle(32'hFFFFFFF1, 32'h0, 1'b0, rd);
    check("cnt_after_clear", rd, 32'd1);

    check("err_before", 32'(err_sticky), 32'd0);
    core_cycle(32'h00000300, 32'h12345678, 1'b1, rd);
    check("err_after", 32'(err_sticky), 32'd1);
    core_cycle(32'hFFFFFFF2, 32'h0, 1'b0, rd);
    check("status", rd, 32'h3);
    readback_all();

    core_cycle(32'hFFFFFFF3, 32'hCAFEBABE, 1'b1, rd);
    core_cycle(32'hFFFFFFF3, 32'h0, 1'b0, rd);
    check("scratch", rd, 32'hCAFEBABE);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0, 1:    addr = 32'($urandom_range(0, 255));
        2:       addr = {28'hFFFFFFF, 4'($urandom_range(0, 15))};
        default: addr = 32'h100 + 32'($urandom_range(0, 4096));
      endcase
      load_valid = 1'($urandom); load_addr = 8'($urandom); load_data = $urandom;
      load_last = 1'($urandom);
      core_cycle(addr, $urandom, 1'($urandom), rd);
      check("load_ready_run", 32'(load_ready), 32'd0);
    end
    load_valid = 1'b0; load_last = 1'b0;
    readback_all();

    do_reset();
    load_beat(8'd0, 32'hCAFEF00D, 1'b0);
    do_reset();
    check("hold_after_rerst", 32'(cpu_hold), 32'd1);
    load_beat(8'd5, 32'h00000055, 1'b1);
    core_cycle(32'd0, 32'h0, 1'b0, rd);
    check("ram0_discarded", rd, 32'h0);
    core_cycle(32'd5, 32'h0, 1'b0, rd);
    check("ram5_loaded", rd, 32'h55);
    readback_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
